pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width (register data, immediate, register indices packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 12, SHALL set the control-field width (ALU control, ALUSrc, RegWrite, MemtoReg, MemWrite, RegDst, Branch).
REQ-003 Parameter CNT_W, default 16, SHALL set the performance counter width.
REQ-004 clk  in  1  the single clock; all state SHALL change on its rising edge only.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  the upstream stage presents a valid entry.
REQ-007 in_ready  out  1  the stage can accept an entry; SHALL be driven directly from a flop.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_ctrl  in  CTRL_W  upstream control field.
REQ-010 flush  in  1  synchronous kill of all held entries (branch taken, hazard bubble).
REQ-011 out_valid  out  1  the output entry is valid.
REQ-012 out_ready  in  1  the downstream stage accepts the output entry.
REQ-013 out_data  out  DATA_W  the head-entry payload.
REQ-014 out_ctrl  out  CTRL_W  the head-entry control field.
REQ-015 occupancy  out  2  the number of held entries (0..2).

Function
REQ-016 A transfer SHALL occur on the input when in_valid&in_ready&~flush, and on the output when out_valid&out_ready.
REQ-017 Storage SHALL consist of a main register (head) and a skid register; FSM states EMPTY (0 entries), BUSY (main only) and FULL (main+skid).
REQ-018 EMPTY: on an input transfer, main<=input and the FSM SHALL go to BUSY; otherwise it SHALL stay in EMPTY.
REQ-019 BUSY with input and output transfer: main<=input and the FSM SHALL stay in BUSY; with input only: skid<=input and go to FULL; with output only: go to EMPTY; with neither: hold.
REQ-020 FULL: on an output transfer, main<=skid and the FSM SHALL go to BUSY; in_ready=0, so no input is accepted.
REQ-021 in_ready SHALL be 1 in the cycle after the next state is EMPTY or BUSY, and 0 in the cycle after the next state is FULL.
REQ-022 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 entry per cycle with out_ready held high.
REQ-023 flush SHALL have priority over every other event: next state EMPTY, any concurrent input entry dropped, occupancy 0.
REQ-024 Entries SHALL leave the stage in arrival order; no entry SHALL be duplicated or lost, except by flush.
REQ-025 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble = NOP).
REQ-026 out_data SHALL hold its last value when out_valid=0.
REQ-027 out_valid SHALL be 1 exactly in BUSY and FULL.

Reset
REQ-028 rst=1 SHALL immediately force EMPTY, out_valid=0, in_ready=0, out_ctrl=0, out_data=0, skid=0 and occupancy=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-030 A reset asserted mid-transfer SHALL discard all entries.

Configuration
REQ-031 With the macro PIPE_STAGE_REG_PERF_EN defined, the module SHALL add the input clr_cnt (1 bit) and the outputs stall_cnt and flush_cnt (CNT_W bits each).
REQ-032 With the macro defined, stall_cnt SHALL count cycles with out_valid&~out_ready, and flush_cnt SHALL count cycles in which flush kills at least one entry.
REQ-033 The counters SHALL saturate at all-ones, be cleared by rst or clr_cnt, and clr_cnt SHALL take priority over counting.
REQ-034 Without the macro, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-035 Package pipe_pkg SHALL hold the FSM state typedef (EMPTY/BUSY/FULL) and the default width constants.
REQ-036 The saturating counter SHALL be the sub-module sat_counter, instantiated twice under PIPE_STAGE_REG_PERF_EN.

Verification
REQ-037 Reset release, then in_data=0x1234, in_ctrl=0x0A5 with in_valid=1 for 1 cycle -> next cycle out_valid=1, out_data=0x1234, out_ctrl=0x0A5, occupancy=1.
REQ-038 Stream 0x1..0x8 back to back with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, in_ready constantly 1.
REQ-039 out_ready=0 while 3 entries 0xA,0xB,0xC are offered -> 0xA,0xB held, occupancy=2, in_ready=0; out_ready=1 -> 0xA,0xB,0xC emitted in order, nothing lost.
REQ-040 flush asserted in FULL together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; the flushed entries never appear.
REQ-041 rst asserted asynchronously mid-stream (between edges) -> out_valid and in_ready fall immediately, before the next clk edge.
REQ-042 With PIPE_STAGE_REG_PERF_EN, CNT_W=4 and 20 stall cycles -> stall_cnt=15 (saturated); clr_cnt pulse -> stall_cnt=0 on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared FSM state type and default widths for the pipeline stage register.
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_CTRL_W = 12;
   localparam int PIPE_CNT_W  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stageState_t;

   function automatic logic [1:0] entriesIn(input stageState_t s);
      case (s)
         EMPTY:   return 2'd0;
         BUSY:    return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Main+skid valid/ready stage register: 1-cycle latency, full throughput, in_ready straight from a flop.
// Flush kills everything held. Stall/flush counters exist only with PIPE_STAGE_REG_PERF_EN defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : gBadParams
      $error("pipe_stage_reg: widths must be at least 1");
   end

   stageState_t       state;
   stageState_t       nextState;
   logic              inReadyQ;
   logic              outValidQ;
   logic [1:0]        occQ;
   logic [DATA_W-1:0] mainData;
   logic [CTRL_W-1:0] mainCtrl;
   logic [DATA_W-1:0] skidData;
   logic [CTRL_W-1:0] skidCtrl;
   logic              inXfer;
   logic              outXfer;

   assign inXfer  = in_valid & inReadyQ & ~flush;
   assign outXfer = outValidQ & out_ready;

   always_comb begin
      nextState = state;
      if (flush) begin
         nextState = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (inXfer) nextState = BUSY;
            BUSY: begin
               if (inXfer && !outXfer)      nextState = FULL;
               else if (!inXfer && outXfer) nextState = EMPTY;
            end
            FULL:    if (outXfer) nextState = BUSY;
            default: nextState = EMPTY;
         endcase
      end
   end

   // Status flags are registered from nextState so in_ready never has a combinational path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         inReadyQ  <= 1'b0;
         outValidQ <= 1'b0;
         occQ      <= 2'd0;
         mainData  <= '0;
         mainCtrl  <= '0;
         skidData  <= '0;
         skidCtrl  <= '0;
      end else begin
         state     <= nextState;
         inReadyQ  <= (nextState != FULL);
         outValidQ <= (nextState != EMPTY);
         occQ      <= entriesIn(nextState);
         if (!flush) begin
            case (state)
               EMPTY: begin
                  if (inXfer) begin
                     mainData <= in_data;
                     mainCtrl <= in_ctrl;
                  end
               end
               BUSY: begin
                  if (inXfer && outXfer) begin
                     mainData <= in_data;
                     mainCtrl <= in_ctrl;
                  end else if (inXfer) begin
                     skidData <= in_data;
                     skidCtrl <= in_ctrl;
                  end
               end
               FULL: begin
                  if (outXfer) begin
                     mainData <= skidData;
                     mainCtrl <= skidCtrl;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready  = inReadyQ;
   assign out_valid = outValidQ;
   assign out_data  = mainData;
   assign out_ctrl  = outValidQ ? mainCtrl : '0;
   assign occupancy = occQ;

`ifdef PIPE_STAGE_REG_PERF_EN
   logic stallEvt;
   logic killEvt;

   assign stallEvt = outValidQ & ~out_ready;
   // A flush only counts if it discards something: a held entry or an input that would have been taken.
   assign killEvt  = flush & (outValidQ | (in_valid & inReadyQ));

   sat_counter #(.W(CNT_W)) uStallCnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_cnt),
      .inc   (stallEvt),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) uFlushCnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_cnt),
      .inc   (killEvt),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_PERF_EN
   localparam int TB_CNT_W = 4;
`else
   localparam int TB_CNT_W = 16;
`endif

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReadyO;
   logic [31:0] inData;
   logic [11:0] inCtrl;
   logic        flush;
   logic        outValidO;
   logic        outReady;
   logic [31:0] outDataO;
   logic [11:0] outCtrlO;
   logic [1:0]  occO;
`ifdef PIPE_STAGE_REG_PERF_EN
   logic                clrCnt;
   logic [TB_CNT_W-1:0] stallCntO;
   logic [TB_CNT_W-1:0] flushCntO;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: ordered list of held entries plus last head payload.
   logic [31:0] mData[$];
   logic [11:0] mCtrl[$];
   logic        mInRdy;
   logic [31:0] mLast;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .CNT_W(TB_CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReadyO),
      .in_data   (inData),
      .in_ctrl   (inCtrl),
      .flush     (flush),
      .out_valid (outValidO),
      .out_ready (outReady),
      .out_data  (outDataO),
      .out_ctrl  (outCtrlO),
      .occupancy (occO)
`ifdef PIPE_STAGE_REG_PERF_EN
      ,
      .clr_cnt   (clrCnt),
      .stall_cnt (stallCntO),
      .flush_cnt (flushCntO)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic modelClear();
      mData.delete();
      mCtrl.delete();
      mInRdy = 1'b0;
      mLast  = '0;
   endtask

   task automatic tick();
      logic outX;
      logic inX;
      @(posedge clk);
      if (rst) begin
         modelClear();
      end else begin
         if (flush) begin
            mData.delete();
            mCtrl.delete();
         end else begin
            outX = (mData.size() != 0) && outReady;
            inX  = inValid && mInRdy;
            if (outX) begin
               void'(mData.pop_front());
               void'(mCtrl.pop_front());
            end
            if (inX) begin
               mData.push_back(inData);
               mCtrl.push_back(inCtrl);
            end
         end
         mInRdy = (mData.size() < 2);
         if (mData.size() != 0) mLast = mData[0];
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; inValid = 0; inData = '0; inCtrl = '0; flush = 0; outReady = 0;
`ifdef PIPE_STAGE_REG_PERF_EN
      clrCnt = 0;
`endif
      modelClear();
      #2;
      checks++; if (outValidO !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", outValidO); end
      checks++; if (inReadyO !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", inReadyO); end
      checks++; if (outCtrlO !== 12'h0) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=000", outCtrlO); end
      checks++; if (outDataO !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", outDataO); end
      checks++; if (occO !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occO); end
      tick();
      tick();
      rst = 1'b0;
      #2;
      checks++; if (inReadyO !== 1'b0) begin errors++; $display("FAIL in_ready_before_edge got=%0b exp=0", inReadyO); end
      tick();
      checks++; if (inReadyO !== 1'b1) begin errors++; $display("FAIL in_ready_after_release got=%0b exp=1", inReadyO); end
   endtask

   task automatic test_single();
      inValid = 1; inData = 32'h1234; inCtrl = 12'h0A5; outReady = 0;
      tick();
      inValid = 0;
      checks++; if (outValidO !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", outValidO); end
      checks++; if (outDataO !== 32'h1234) begin errors++; $display("FAIL single_data got=%h exp=1234", outDataO); end
      checks++; if (outCtrlO !== 12'h0A5) begin errors++; $display("FAIL single_ctrl got=%h exp=0a5", outCtrlO); end
      checks++; if (occO !== 2'd1) begin errors++; $display("FAIL single_occ got=%0d exp=1", occO); end
      outReady = 1;
      tick();
      checks++; if (outValidO !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", outValidO); end
   endtask

   task automatic test_back_to_back();
      outReady = 1;
      for (int i = 1; i <= 8; i++) begin
         inValid = 1; inData = i; inCtrl = 12'(i + 16);
         tick();
         checks++; if (outDataO !== 32'(i) || outValidO !== 1'b1) begin
            errors++; $display("FAIL b2b_data[%0d] got=%h/%0b exp=%h/1", i, outDataO, outValidO, i);
         end
         checks++; if (inReadyO !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, inReadyO); end
      end
      inValid = 0;
      tick();
      checks++; if (outValidO !== 1'b0 || outCtrlO !== 12'h0) begin
         errors++; $display("FAIL b2b_bubble got=%0b/%h exp=0/000", outValidO, outCtrlO);
      end
      checks++; if (outDataO !== 32'h8) begin errors++; $display("FAIL b2b_data_hold got=%h exp=8", outDataO); end
   endtask

   task automatic test_backpressure();
      logic [31:0] seen[$];
      outReady = 0; inValid = 1; inCtrl = 12'h3C;
      inData = 32'hA; tick();
      inData = 32'hB; tick();
      inData = 32'hC; tick();
      checks++; if (occO !== 2'd2) begin errors++; $display("FAIL bp_occ got=%0d exp=2", occO); end
      checks++; if (inReadyO !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", inReadyO); end
      checks++; if (outDataO !== 32'hA) begin errors++; $display("FAIL bp_head got=%h exp=a", outDataO); end
      outReady = 1;
      for (int k = 0; k < 6; k++) begin
         if (outValidO) seen.push_back(outDataO);
         tick();
         if (k == 1) inValid = 0;
      end
      checks++; if (seen.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", seen.size()); end
      else begin
         checks++; if (seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
            errors++; $display("FAIL bp_order got=%h,%h,%h exp=a,b,c", seen[0], seen[1], seen[2]);
         end
      end
   endtask

   task automatic test_flush();
      int leaks = 0;
      outReady = 0; inValid = 1; inCtrl = 12'h7;
      inData = 32'h11; tick();
      inData = 32'h22; tick();
      checks++; if (occO !== 2'd2) begin errors++; $display("FAIL flush_fill got=%0d exp=2", occO); end
      flush = 1; inData = 32'h33;
      tick();
      flush = 0; inValid = 0;
      checks++; if (occO !== 2'd0 || outValidO !== 1'b0) begin
         errors++; $display("FAIL flush_empty got=%0d/%0b exp=0/0", occO, outValidO);
      end
      checks++; if (outCtrlO !== 12'h0) begin errors++; $display("FAIL flush_ctrl got=%h exp=000", outCtrlO); end
      checks++; if (inReadyO !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", inReadyO); end
      outReady = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (outValidO) leaks++;
      end
      checks++; if (leaks != 0) begin errors++; $display("FAIL flush_leak got=%0d exp=0", leaks); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         inValid  = ($urandom_range(0, 3) != 0);
         outReady = (n % 64 < 32) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 24) == 0);
         inData   = $urandom;
         inCtrl   = 12'($urandom);
         tick();
         checks++; if (occO !== 2'(mData.size()) || outValidO !== (mData.size() != 0)) begin
            errors++; $display("FAIL rand_occ[%0d] got=%0d/%0b exp=%0d", n, occO, outValidO, mData.size());
         end
         checks++; if (outDataO !== mLast) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, outDataO, mLast); end
         checks++; if (outCtrlO !== ((mData.size() != 0) ? mCtrl[0] : 12'h0)) begin
            errors++; $display("FAIL rand_ctrl[%0d] got=%h exp=%h", n, outCtrlO, (mData.size() != 0) ? mCtrl[0] : 12'h0);
         end
         checks++; if (inReadyO !== mInRdy) begin errors++; $display("FAIL rand_in_ready[%0d] got=%0b exp=%0b", n, inReadyO, mInRdy); end
      end
      flush = 0;
   endtask

   task automatic test_async_reset();
      outReady = 1; inValid = 1; inCtrl = 12'h5;
      inData = 32'h91; tick();
      inData = 32'h92; tick();
      #3;
      rst = 1'b1;
      #1;
      checks++; if (outValidO !== 1'b0 || inReadyO !== 1'b0) begin
         errors++; $display("FAIL async_rst got=%0b/%0b exp=0/0", outValidO, inReadyO);
      end
      checks++; if (outDataO !== 32'h0 || occO !== 2'd0) begin
         errors++; $display("FAIL async_rst_data got=%h/%0d exp=0/0", outDataO, occO);
      end
      modelClear();
      inValid = 0;
      tick();
      rst = 1'b0;
      tick();
      checks++; if (inReadyO !== 1'b1 || outValidO !== 1'b0) begin
         errors++; $display("FAIL async_rst_release got=%0b/%0b exp=1/0", inReadyO, outValidO);
      end
   endtask

`ifdef PIPE_STAGE_REG_PERF_EN
   task automatic test_perf();
      outReady = 0; inValid = 1; inData = 32'h55; inCtrl = 12'h1;
      tick();
      inValid = 0; clrCnt = 1;
      tick();
      clrCnt = 0;
      checks++; if (stallCntO !== 4'd0 || flushCntO !== 4'd0) begin
         errors++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", stallCntO, flushCntO);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 14) begin
            checks++; if (stallCntO !== 4'd14) begin errors++; $display("FAIL perf_stall14 got=%0d exp=14", stallCntO); end
         end
      end
      checks++; if (stallCntO !== 4'd15) begin errors++; $display("FAIL perf_stall_sat got=%0d exp=15", stallCntO); end
      clrCnt = 1;
      tick();
      clrCnt = 0;
      checks++; if (stallCntO !== 4'd0) begin errors++; $display("FAIL perf_clr got=%0d exp=0", stallCntO); end
      flush = 1;
      tick();
      tick();
      flush = 0;
      checks++; if (flushCntO !== 4'd1) begin errors++; $display("FAIL perf_flush got=%0d exp=1", flushCntO); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_random();
      test_async_reset();
`ifdef PIPE_STAGE_REG_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
